// File: rtl/vga_pkg.sv
// Shared constants for the VRAM write path: command encodings, FSM codes, sizes,
// and the FIFO entry layout.
package vga_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int FIFO_DEPTH  = 4;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] CMD_CUR_LO = 2'b00;
    localparam logic [1:0] CMD_CUR_HI = 2'b01;
    localparam logic [1:0] CMD_WRITE  = 2'b10;
    localparam logic [1:0] CMD_NOP    = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SETUP  = 2'b01;
    localparam logic [1:0] ST_STROBE = 2'b10;
    localparam logic [1:0] ST_HOLD   = 2'b11;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [7:0]             data;
    } wr_entry_t;

    // Cursor advance; the natural 13-bit overflow gives the 8191 -> 0 wrap.
    function automatic logic [VRAM_ADDR_W-1:0] cursorInc(input logic [VRAM_ADDR_W-1:0] c);
        return c + 1'b1;
    endfunction

endpackage

// File: rtl/vram_writer_if.sv
// Host command bus: one-cycle strobe with command/operand, back-pressure via hostReady.
interface vram_writer_if;
    logic       hostStrobe;
    logic [1:0] hostCmd;
    logic [7:0] hostData;
    logic       hostReady;

    modport master (output hostStrobe, hostCmd, hostData, input hostReady);
    modport slave  (input hostStrobe, hostCmd, hostData, output hostReady);
endinterface

// File: rtl/vram_wr_fifo.sv
// Small write FIFO holding {address, data} until the VRAM bus is free.
// Pushes while full and pops while empty are ignored internally.
module vram_wr_fifo
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic             pop,
    input  wr_entry_t        din,
    output wr_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    wr_entry_t        mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic             doPush, doPop;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign head   = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_ONE;
            if (doPop)  rdPtr <= rdPtr + PTR_ONE;
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vram_writer.sv
// Host-to-VRAM write path: cursor register, write FIFO and bus sequencer that yields
// to the display readout. Define VRAM_WRITER_AUTOINC_EN to auto-advance the cursor on writes.
module vram_writer
    import vga_pkg::*;
(
    input  logic                   clk,
    input  logic                   nrst,
    vram_writer_if.slave           host,
    input  logic                   displayActive,
    output logic [VRAM_ADDR_W-1:0] vramAddr,
    output logic [7:0]             vramData,
    output logic                   vramWe,
    output logic                   overflow
);

    logic [VRAM_ADDR_W-1:0] cursor;
    logic [1:0]             state, nextState;
    logic                   isWrite, pop, full, empty;
    logic [CNT_W-1:0]       count;
    wr_entry_t              head, din;

    assign isWrite        = host.hostStrobe && (host.hostCmd == CMD_WRITE);
    assign pop            = (state == ST_HOLD);
    assign din.addr       = cursor;
    assign din.data       = host.hostData;
    assign host.hostReady = !full;

    vram_wr_fifo uFifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (isWrite),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cursor <= '0;
        end else if (host.hostStrobe) begin
            case (host.hostCmd)
                CMD_CUR_LO: cursor[7:0]             <= host.hostData;
                CMD_CUR_HI: cursor[VRAM_ADDR_W-1:8] <= host.hostData[VRAM_ADDR_W-9:0];
`ifdef VRAM_WRITER_AUTOINC_EN
                CMD_WRITE:  if (!full) cursor <= cursorInc(cursor);
`endif
                default:    cursor <= cursor;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst)                overflow <= 1'b0;
        else if (isWrite && full) overflow <= 1'b1;
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:   if (!empty && !displayActive) nextState = ST_SETUP;
            ST_SETUP:  nextState = displayActive ? ST_IDLE : ST_STROBE;
            ST_STROBE: nextState = ST_HOLD;
            ST_HOLD:   nextState = ST_IDLE;
            default:   nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= nextState;
    end

    // Bus outputs are registered: address/data launch out of SETUP, the write
    // pulse out of STROBE, so addr/data are stable a full cycle before and after vramWe.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            vramAddr <= '0;
            vramData <= '0;
            vramWe   <= 1'b0;
        end else begin
            vramWe <= (state == ST_STROBE);
            if (state == ST_SETUP && !displayActive) begin
                vramAddr <= head.addr;
                vramData <= head.data;
            end
        end
    end

endmodule

// File: doc/vram_writer.md
VRAM_WRITER -- requirements
Module: vram_writer

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: nrst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: hostStrobe  in  1  one-cycle host command valid.
REQ-004 SHALL have port: hostCmd  in  2  00=set cursor[7:0], 01=set cursor[12:8] (hostData[4:0]), 10=write data, 11=no-op.
REQ-005 SHALL have port: hostData  in  8  command operand.
REQ-006 SHALL have port: displayActive  in  1  high while the display readout owns VRAM.
REQ-007 SHALL have port: hostReady  out  1  high when the write FIFO is not full.
REQ-008 SHALL have port: vramAddr  out  13  VRAM write address.
REQ-009 SHALL have port: vramData  out  8  VRAM write data.
REQ-010 SHALL have port: vramWe  out  1  VRAM write enable, active-high, one cycle per write.
REQ-011 SHALL have port: overflow  out  1  sticky flag: a data write was dropped.

Function
REQ-012 SHALL keep a 13-bit cursor; commands 00/01 update only the addressed cursor bits in the cycle after the strobe.
REQ-013 SHALL push {cursor, hostData} into a 4-entry FIFO on a strobe with cmd 10 when the registered count is below 4.
REQ-014 SHALL drop a cmd-10 strobe when count==4, even if a pop occurs in the same cycle, and set overflow.
REQ-015 SHALL accept cursor commands regardless of FIFO state.
REQ-016 SHALL drive hostReady = (count != 4) from registered state.
REQ-017 SHALL run FSM IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE->SETUP: FIFO non-empty and displayActive low.
- SETUP: vramAddr/vramData = FIFO head, vramWe low; if displayActive high, return to IDLE without popping.
- STROBE: vramWe high exactly one cycle; completes regardless of displayActive.
- HOLD: vramWe low, addr/data held; head popped at exit.
REQ-018 SHALL hold vramAddr/vramData at the last written value while in IDLE.
REQ-019 SHALL support a simultaneous push and pop with count unchanged.
REQ-020 SHALL wrap FIFO pointers modulo 4 and the cursor from 8191 to 0.
REQ-021 SHALL give 4-cycle minimum latency from a cmd-10 strobe to vramWe high when the FIFO is empty and displayActive is low.

Reset
REQ-022 SHALL, while nrst low at a clock edge, set FSM=IDLE, cursor=0, FIFO empty, vramAddr=0, vramData=0, vramWe=0, overflow=0, hostReady=1.
REQ-023 SHALL abandon an in-progress write on mid-operation reset, with vramWe low from the next edge.

Configuration
REQ-024 SHALL, with VRAM_WRITER_AUTOINC_EN defined, increment the cursor by 1 (mod 8192) on each accepted cmd-10 push.
REQ-025 SHALL, without VRAM_WRITER_AUTOINC_EN, leave the cursor unchanged by data writes.

Structure
REQ-026 SHALL take command encodings, FSM state codes, VRAM_ADDR_W=13 and FIFO_DEPTH=4 from shared package vga_pkg.
REQ-027 SHALL place the FIFO in one sub-module, vram_wr_fifo.

Verification
REQ-028 Reset, then cursor 0x12/0x05 and write 0x41 -> one vramWe pulse, vramAddr=0x0512, vramData=0x41, 4 cycles after the data strobe.
REQ-029 AUTOINC: 3 writes from cursor 0x1FFF -> addresses 0x1FFF, 0x0000, 0x0001; without the macro, all three go to 0x1FFF.
REQ-030 displayActive high, 6 writes -> hostReady low after 4, overflow=1, no vramWe; drop displayActive -> exactly 4 writes, in order.
REQ-031 displayActive rises in SETUP -> no vramWe, entry retained; rises in STROBE -> write completes.
REQ-032 nrst low during STROBE -> vramWe=0 next cycle, FIFO empty, overflow=0, cursor=0.
